// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480@60 video timing generator.
// Default timing values, derived totals and the coordinate width live here.
package vga_timing_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [COORD_W-1:0] coord_t;

  // Everything the output stage registers besides the coordinates.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic frame_start;
    logic line_start;
  } timing_t;

  function automatic logic in_window(coord_t c, int unsigned lo, int unsigned hi);
    return (32'(c) >= lo) && (32'(c) < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..TOTAL-1 while enabled and flags the wrap cycle.
// Used once per line (horizontal) and once per frame (vertical).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL = DEF_H_TOTAL
) (
  input  logic   clk,
  input  logic   i_rst_n,
  input  logic   i_en,
  output coord_t o_count,
  output logic   o_wrap
);

  localparam coord_t LAST = COORD_W'(TOTAL - 1);

  coord_t r_count;

  assign o_wrap  = i_en && (r_count == LAST);
  assign o_count = r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (o_wrap) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// Video timing generator: syncs, display enable, coordinates and line/frame pulses.
// Optional vblank interrupt enabled by defining VGA_VBLANK_IRQ_EN.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               locked,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               frame_start,
  output logic               line_start,
  output logic               irq,
  input  logic               irq_ack
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_timing
      $error("vga_timing: H_TOTAL/V_TOTAL exceed the coordinate width");
    end
  endgenerate

  localparam timing_t RST_OUT = '{hsync: !SYNC_POL, vsync: !SYNC_POL, de: 1'b0,
                                  frame_start: 1'b0, line_start: 1'b0};

  // Losing PLL lock is treated exactly like a reset request.
  logic    w_rst_n;
  coord_t  w_hcnt;
  coord_t  w_vcnt;
  logic    w_h_wrap;
  logic    w_unused_v_wrap;
  timing_t w_dec;
  timing_t r_out;
  coord_t  r_x;
  coord_t  r_y;

  assign w_rst_n = reset_n & locked;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_counter (
    .clk     (clock),
    .i_rst_n (w_rst_n),
    .i_en    (1'b1),
    .o_count (w_hcnt),
    .o_wrap  (w_h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_counter (
    .clk     (clock),
    .i_rst_n (w_rst_n),
    .i_en    (w_h_wrap),
    .o_count (w_vcnt),
    .o_wrap  (w_unused_v_wrap)
  );

  always_comb begin
    w_dec.de          = (32'(w_hcnt) < H_ACTIVE) && (32'(w_vcnt) < V_ACTIVE);
    w_dec.hsync       = in_window(w_hcnt, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC)
                        ? SYNC_POL : !SYNC_POL;
    w_dec.vsync       = in_window(w_vcnt, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC)
                        ? SYNC_POL : !SYNC_POL;
    w_dec.line_start  = (w_hcnt == '0);
    w_dec.frame_start = (w_hcnt == '0) && (w_vcnt == '0);
  end

  // Outputs describe the counter state of the previous cycle, all aligned.
  always_ff @(posedge clock) begin
    if (!w_rst_n) begin
      r_out <= RST_OUT;
      r_x   <= '0;
      r_y   <= '0;
    end else begin
      r_out <= w_dec;
      r_x   <= w_hcnt;
      r_y   <= w_vcnt;
    end
  end

  assign hsync       = r_out.hsync;
  assign vsync       = r_out.vsync;
  assign de          = r_out.de;
  assign frame_start = r_out.frame_start;
  assign line_start  = r_out.line_start;
  assign pixel_x     = r_x;
  assign pixel_y     = r_y;

`ifdef VGA_VBLANK_IRQ_EN
  logic r_irq;

  // Setting on the first vblank line takes priority over a coincident ack.
  always_ff @(posedge clock) begin
    if (!w_rst_n) begin
      r_irq <= 1'b0;
    end else if (w_hcnt == '0 && 32'(w_vcnt) == V_ACTIVE) begin
      r_irq <= 1'b1;
    end else if (irq_ack) begin
      r_irq <= 1'b0;
    end
  end

  assign irq = r_irq;
`else
  logic w_unused_irq_ack;
  assign w_unused_irq_ack = irq_ack;
  assign irq              = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: a default 640x480 instance and a small,
// positive-polarity instance checked every cycle against a pixel-index model.
module tb_vga_timing;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit pol;
  } tim_t;

  localparam int B_HA = 20, B_HF = 3, B_HS = 5, B_HB = 4;
  localparam int B_VA = 10, B_VF = 2, B_VS = 2, B_VB = 3;
  localparam int B_HT = B_HA + B_HF + B_HS + B_HB;  // 32
  localparam int B_VT = B_VA + B_VF + B_VS + B_VB;  // 17
  localparam int B_FRAME = B_HT * B_VT;             // 544

  tim_t TA = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
  tim_t TB = '{B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, locked, irq_ack;
  logic a_hs, a_vs, a_de, a_fs, a_ls, a_irq;
  logic b_hs, b_vs, b_de, b_fs, b_ls, b_irq;
  logic [9:0] a_x, a_y, b_x, b_y;

  wire [25:0] a_vec = {a_hs, a_vs, a_de, a_fs, a_ls, a_irq, a_x, a_y};
  wire [25:0] b_vec = {b_hs, b_vs, b_de, b_fs, b_ls, b_irq, b_x, b_y};

  int n_checks = 0;
  int n_pass   = 0;

  vga_timing u_dut_a (
    .clock(clk), .reset_n(reset_n), .locked(locked),
    .hsync(a_hs), .vsync(a_vs), .de(a_de), .pixel_x(a_x), .pixel_y(a_y),
    .frame_start(a_fs), .line_start(a_ls), .irq(a_irq), .irq_ack(irq_ack)
  );

  vga_timing #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB), .SYNC_POL(1'b1)
  ) u_dut_b (
    .clock(clk), .reset_n(reset_n), .locked(locked),
    .hsync(b_hs), .vsync(b_vs), .de(b_de), .pixel_x(b_x), .pixel_y(b_y),
    .frame_start(b_fs), .line_start(b_ls), .irq(b_irq), .irq_ack(irq_ack)
  );

  // Model: age counts non-reset edges; the displayed pixel index is age-1.
  int age = 0;
  bit irq_ma = 1'b0, irq_mb = 1'b0;

  function automatic bit irq_next(bit cur, int pix, tim_t t, bit ack);
`ifdef VGA_VBLANK_IRQ_EN
    int ht = t.ha + t.hf + t.hs + t.hb;
    int vt = t.va + t.vf + t.vs + t.vb;
    if ((pix % ht) == 0 && ((pix / ht) % vt) == t.va) return 1'b1;
    if (ack) return 1'b0;
    return cur;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    if (!reset_n || !locked) begin
      age    <= 0;
      irq_ma <= 1'b0;
      irq_mb <= 1'b0;
    end else begin
      age    <= age + 1;
      irq_ma <= irq_next(irq_ma, age, TA, irq_ack);
      irq_mb <= irq_next(irq_mb, age, TB, irq_ack);
    end
  end

  function automatic logic [25:0] exp_vec(int a, bit irq, tim_t t);
    int ht = t.ha + t.hf + t.hs + t.hb;
    int vt = t.va + t.vf + t.vs + t.vb;
    int p, x, y;
    logic hs, vs, de, fs, ls;
    if (a == 0) return {~t.pol, ~t.pol, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
    p  = a - 1;
    x  = p % ht;
    y  = (p / ht) % vt;
    hs = (x >= t.ha + t.hf && x < t.ha + t.hf + t.hs) ? t.pol : ~t.pol;
    vs = (y >= t.va + t.vf && y < t.va + t.vf + t.vs) ? t.pol : ~t.pol;
    de = (x < t.ha) && (y < t.va);
    fs = (x == 0) && (y == 0);
    ls = (x == 0);
    return {hs, vs, de, fs, ls, irq, 10'(x), 10'(y)};
  endfunction

  function automatic bit b_at(int x, int y);
    return age >= 1 && ((age - 1) % B_HT) == x && (((age - 1) / B_HT) % B_VT) == y;
  endfunction

  task automatic wait_b(int x, int y, int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (b_at(x, y)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; locked = 1'b1; irq_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({a_vec, b_vec} !== {exp_vec(age, irq_ma, TA), exp_vec(age, irq_mb, TB)})
        $display("FAIL reset_hold: got A=%h B=%h expected A=%h B=%h", a_vec, b_vec,
                 exp_vec(age, irq_ma, TA), exp_vec(age, irq_mb, TB));
      else n_pass++;
    end
    reset_n = 1'b1;
    n_checks++;
    if ({a_hs, a_vs, a_de, a_fs, a_ls, a_x, a_y} !== {5'b11000, 20'd0})
      $display("FAIL reset_first_cycle: got %b expected %b",
               {a_hs, a_vs, a_de, a_fs, a_ls, a_x, a_y}, {5'b11000, 20'd0});
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({a_de, a_fs, a_ls, a_x, a_y, b_de, b_fs, b_hs} !== {3'b111, 20'd0, 3'b110})
      $display("FAIL reset_release_origin: got %b expected %b",
               {a_de, a_fs, a_ls, a_x, a_y, b_de, b_fs, b_hs}, {3'b111, 20'd0, 3'b110});
    else n_pass++;
  endtask

  task automatic test_line();
    int de_cnt = 0, hs_cnt = 0, hs_first = -1, hs_last = -1;
    int ls_q[$];
    for (int i = 0; i <= 1600; i++) begin
      n_checks++;
      if ({a_vec, b_vec} !== {exp_vec(age, irq_ma, TA), exp_vec(age, irq_mb, TB)})
        $display("FAIL line_model: got A=%h B=%h expected A=%h B=%h", a_vec, b_vec,
                 exp_vec(age, irq_ma, TA), exp_vec(age, irq_mb, TB));
      else n_pass++;
      if (i < 800 && a_de === 1'b1) de_cnt++;
      if (i < 800 && a_hs === 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(a_x);
        hs_last = int'(a_x);
      end
      if (a_ls === 1'b1) ls_q.push_back(i);
      @(negedge clk);
    end
    n_checks++;
    if (de_cnt !== 640) $display("FAIL line_de_count: got %0d expected 640", de_cnt);
    else n_pass++;
    n_checks++;
    if (hs_cnt !== 96) $display("FAIL line_hsync_width: got %0d expected 96", hs_cnt);
    else n_pass++;
    n_checks++;
    if (hs_first !== 656 || hs_last !== 751)
      $display("FAIL line_hsync_span: got %0d..%0d expected 656..751", hs_first, hs_last);
    else n_pass++;
    n_checks++;
    if (ls_q.size() !== 3 || ls_q[1] - ls_q[0] !== 800 || ls_q[2] - ls_q[1] !== 800)
      $display("FAIL line_start_period: got %0d pulses first gap %0d expected 3 pulses gap 800",
               ls_q.size(), ls_q.size() > 1 ? ls_q[1] - ls_q[0] : -1);
    else n_pass++;
  endtask

  task automatic test_frames();
    int fs_q[$];
    int vs_cnt = 0, vs_x = -1, vs_y = -1;
    for (int i = 0; i <= 3 * B_FRAME + 1; i++) begin
      n_checks++;
      if ({a_vec, b_vec} !== {exp_vec(age, irq_ma, TA), exp_vec(age, irq_mb, TB)})
        $display("FAIL frame_model: got A=%h B=%h expected A=%h B=%h", a_vec, b_vec,
                 exp_vec(age, irq_ma, TA), exp_vec(age, irq_mb, TB));
      else n_pass++;
      if (b_fs === 1'b1) fs_q.push_back(i);
      if (fs_q.size() == 1 && b_vs === 1'b1) begin
        if (vs_cnt == 0) begin vs_x = int'(b_x); vs_y = int'(b_y); end
        vs_cnt++;
      end
      irq_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    irq_ack = 1'b0;
    n_checks++;
    if (fs_q.size() < 3 || fs_q[1] - fs_q[0] !== B_FRAME || fs_q[2] - fs_q[1] !== B_FRAME)
      $display("FAIL frame_start_period: got %0d pulses first gap %0d expected gap %0d",
               fs_q.size(), fs_q.size() > 1 ? fs_q[1] - fs_q[0] : -1, B_FRAME);
    else n_pass++;
    n_checks++;
    if (vs_cnt !== B_VS * B_HT)
      $display("FAIL frame_vsync_width: got %0d expected %0d", vs_cnt, B_VS * B_HT);
    else n_pass++;
    n_checks++;
    if (vs_x !== 0 || vs_y !== B_VA + B_VF)
      $display("FAIL frame_vsync_start: got (%0d,%0d) expected (0,%0d)", vs_x, vs_y, B_VA + B_VF);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit found;
    wait_b(B_HT - 1, B_VT - 1, 2 * B_FRAME, found);
    @(negedge clk);
    n_checks++;
    if (!found || {b_x, b_y, b_fs} !== {20'd0, 1'b1})
      $display("FAIL wrap_frame: found=%0d got x=%0d y=%0d fs=%b expected x=0 y=0 fs=1",
               found, b_x, b_y, b_fs);
    else n_pass++;
    wait_b(B_HT - 1, B_VA - 1, 2 * B_FRAME, found);
    @(negedge clk);
    n_checks++;
    if (!found || {b_x, b_y, b_de} !== {10'd0, 10'(B_VA), 1'b0})
      $display("FAIL wrap_vblank: found=%0d got x=%0d y=%0d de=%b expected x=0 y=%0d de=0",
               found, b_x, b_y, b_de, B_VA);
    else n_pass++;
  endtask

  task automatic test_irq();
    bit found;
    irq_ack = 1'b0;
`ifdef VGA_VBLANK_IRQ_EN
    wait_b(0, 0, 2 * B_FRAME, found);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    n_checks++;
    if (!found || b_irq !== 1'b0)
      $display("FAIL irq_ack_clear_pre: found=%0d got %b expected 0", found, b_irq);
    else n_pass++;
    wait_b(B_HT - 1, B_VA - 1, 2 * B_FRAME, found);
    @(negedge clk);
    n_checks++;
    if (!found || {b_irq, b_x, b_y} !== {1'b1, 10'd0, 10'(B_VA)})
      $display("FAIL irq_rise: found=%0d got irq=%b x=%0d y=%0d expected irq=1 x=0 y=%0d",
               found, b_irq, b_x, b_y, B_VA);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (b_irq !== 1'b1) $display("FAIL irq_hold: got %b expected 1", b_irq);
    else n_pass++;
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    n_checks++;
    if (b_irq !== 1'b0) $display("FAIL irq_ack_clear: got %b expected 0", b_irq);
    else n_pass++;
    wait_b(B_HT - 1, B_VA - 1, 2 * B_FRAME, found);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    n_checks++;
    if (!found || b_irq !== 1'b1)
      $display("FAIL irq_set_wins: found=%0d got %b expected 1", found, b_irq);
    else n_pass++;
`else
    found = 1'b0;
    for (int i = 0; i < B_FRAME + 1; i++) begin
      if (a_irq !== 1'b0 || b_irq !== 1'b0) found = 1'b1;
      irq_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    irq_ack = 1'b0;
    n_checks++;
    if (found) $display("FAIL irq_disabled: got irq high expected 0 for a full frame");
    else n_pass++;
`endif
    n_checks++;
    if ({a_vec, b_vec} !== {exp_vec(age, irq_ma, TA), exp_vec(age, irq_mb, TB)})
      $display("FAIL irq_model: got A=%h B=%h expected A=%h B=%h", a_vec, b_vec,
               exp_vec(age, irq_ma, TA), exp_vec(age, irq_mb, TB));
    else n_pass++;
  endtask

  task automatic test_lock_drop();
    bit found = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (age >= 1 && ((age - 1) % 800) == 300) begin found = 1'b1; break; end
      @(negedge clk);
    end
    locked = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (!found || {a_hs, a_vs, a_de, a_fs, a_ls, a_irq, a_x, a_y} !== {2'b11, 4'b0000, 20'd0}
          || {b_hs, b_vs, b_de, b_irq, b_x} !== {4'b0000, 10'd0})
        $display("FAIL lock_drop_reset: found=%0d got A=%h B=%h expected reset values",
                 found, a_vec, b_vec);
      else n_pass++;
    end
    locked = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({a_de, a_fs, a_ls, a_x, a_y} !== {3'b111, 20'd0})
      $display("FAIL lock_restart: got %b expected %b", {a_de, a_fs, a_ls, a_x, a_y},
               {3'b111, 20'd0});
    else n_pass++;
    // Back-to-back random interruptions from either reset source.
    for (int r = 0; r < 4; r++) begin
      int run = $urandom_range(1, 1500);
      int hold = $urandom_range(1, 4);
      bit use_lock = 1'($urandom_range(0, 1));
      for (int i = 0; i < run + hold + 3; i++) begin
        if (i == run) begin
          if (use_lock) locked = 1'b0; else reset_n = 1'b0;
        end
        if (i == run + hold) begin locked = 1'b1; reset_n = 1'b1; end
        irq_ack = 1'($urandom_range(0, 3) == 0);
        @(negedge clk);
        n_checks++;
        if ({a_vec, b_vec} !== {exp_vec(age, irq_ma, TA), exp_vec(age, irq_mb, TB)})
          $display("FAIL random_model: got A=%h B=%h expected A=%h B=%h", a_vec, b_vec,
                   exp_vec(age, irq_ma, TA), exp_vec(age, irq_mb, TB));
        else n_pass++;
      end
    end
    irq_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_line();
    test_frames();
    test_wrap();
    test_irq();
    test_lock_drop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
